// File: rtl/distinguish_pulse_gen.sv
// rtl/distinguish_pulse_gen.sv - cmp/set stimulus generator for distinguish_counter
// Optional cmp jitter LFSR enabled by DISTINGUISH_PULSE_JITTER_EN.
module distinguish_pulse_gen #(
  parameter int WINDOW_CYCLES = 1000,
  parameter int BASE_PERIOD   = 100,
  parameter int CW            = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] cls_in,
  input  logic       cls_load,
  output logic       cmp_out,
  output logic       set_out,
  output logic [3:0] cls_act,
  output logic [7:0] win_pulses,
  output logic       cls_err
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [CW-1:0] WIN_LAST = CW'(WINDOW_CYCLES - 1);

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] win_q, win_d;
  logic [CW-1:0] per_q, per_d;
  logic [3:0]    cls_act_q, cls_act_d;
  logic [3:0]    cls_pend_q, cls_pend_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    win_pulses_q, win_pulses_d;
  logic          cmp_q, cmp_d;
  logic          set_q, set_d;
  logic          err_q, err_d;

  logic          valid_load;
  logic          run_d;
  logic [8:0]    sum;
  logic [7:0]    cnt_sat;
  logic [CW-1:0] term_d;

`ifdef DISTINGUISH_PULSE_JITTER_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic       lfsr_fb;
`endif

  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    per_d        = per_q;
    cls_act_d    = cls_act_q;
    cls_pend_d   = cls_pend_q;
    cnt_d        = cnt_q;
    win_pulses_d = win_pulses_q;
    valid_load   = cls_load && (cls_in <= 4'd9);
    err_d        = cls_load && (cls_in > 4'd9);
    // A pulse showing this cycle belongs to the current window's tally
    sum          = {1'b0, cnt_q} + {8'd0, cmp_q};
    cnt_sat      = sum[8] ? 8'hFF : sum[7:0];

    if (state_q == ST_IDLE) begin
      win_d = '0;
      per_d = '0;
      cnt_d = '0;
      if (valid_load) begin
        cls_pend_d = cls_in;
        cls_act_d  = cls_in;
      end
      if (en) state_d = ST_RUN;
    end else begin
      if (valid_load) cls_pend_d = cls_in;
      if (!en) begin
        state_d   = ST_IDLE;
        win_d     = '0;
        per_d     = '0;
        cnt_d     = '0;
        cls_act_d = cls_pend_d;
      end else if (win_q == WIN_LAST) begin
        // Boundary swap uses the pending class from before this cycle's load
        win_d        = '0;
        per_d        = '0;
        cnt_d        = '0;
        win_pulses_d = cnt_sat;
        cls_act_d    = cls_pend_q;
      end else begin
        win_d = win_q + CW'(1);
        per_d = cmp_q ? '0 : per_q + CW'(1);
        cnt_d = cnt_sat;
      end
    end

    term_d = CW'(BASE_PERIOD * (int'(cls_act_d) + 1) - 1);
`ifdef DISTINGUISH_PULSE_JITTER_EN
    lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    lfsr_d  = cmp_q ? {lfsr_q[6:0], lfsr_fb} : lfsr_q;
    case (lfsr_d[1:0])
      2'b00:   term_d = term_d - CW'(1);
      2'b10:   term_d = term_d + CW'(1);
      default: ;
    endcase
`endif

    run_d = (state_d == ST_RUN);
    set_d = run_d && (win_d == WIN_LAST);
    cmp_d = run_d && (per_d == term_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      win_q        <= '0;
      per_q        <= '0;
      cls_act_q    <= '0;
      cls_pend_q   <= '0;
      cnt_q        <= '0;
      win_pulses_q <= '0;
      cmp_q        <= 1'b0;
      set_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      per_q        <= per_d;
      cls_act_q    <= cls_act_d;
      cls_pend_q   <= cls_pend_d;
      cnt_q        <= cnt_d;
      win_pulses_q <= win_pulses_d;
      cmp_q        <= cmp_d;
      set_q        <= set_d;
      err_q        <= err_d;
    end
  end

`ifdef DISTINGUISH_PULSE_JITTER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 8'hA5;
    else        lfsr_q <= lfsr_d;
  end
`endif

  assign cmp_out    = cmp_q;
  assign set_out    = set_q;
  assign cls_act    = cls_act_q;
  assign win_pulses = win_pulses_q;
  assign cls_err    = err_q;

endmodule

// File: tb/tb_distinguish_pulse_gen.sv
// tb/tb_distinguish_pulse_gen.sv - self-checking bench for distinguish_pulse_gen
module tb_distinguish_pulse_gen;
  localparam int W = 1000;
  localparam int B = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       cls_load = 1'b0;
  logic [3:0] cls_in = 4'd0;
  logic       cmp_out, set_out, cls_err;
  logic [3:0] cls_act;
  logic [7:0] win_pulses;

  distinguish_pulse_gen #(.WINDOW_CYCLES(W), .BASE_PERIOD(B), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cls_in(cls_in), .cls_load(cls_load),
    .cmp_out(cmp_out), .set_out(set_out), .cls_act(cls_act),
    .win_pulses(win_pulses), .cls_err(cls_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference: window position plus modular arithmetic on the class period
  int m_run, m_w, m_act, m_pend, m_wp, m_err, m_cmp, m_set;

  function automatic int period(input int c);
    return B * (c + 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 50) $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_w = 0; m_act = 0; m_pend = 0; m_wp = 0; m_err = 0; m_cmp = 0; m_set = 0;
  endtask

  task automatic model_edge();
    int  old_pend;
    bit  valid;
    old_pend = m_pend;
    valid = cls_load && (int'(cls_in) <= 9);
    m_err = (cls_load && (int'(cls_in) > 9)) ? 1 : 0;
    if (m_run == 0) begin
      if (valid) begin m_pend = int'(cls_in); m_act = int'(cls_in); end
      if (en) begin m_run = 1; m_w = 0; end
    end else begin
      if (valid) m_pend = int'(cls_in);
      if (!en) begin
        m_run = 0;
        m_act = m_pend;
      end else if (m_w == W - 1) begin
        m_wp  = W / period(m_act);
        m_act = old_pend;
        m_w   = 0;
      end else begin
        m_w++;
      end
    end
    m_cmp = (m_run != 0 && ((m_w + 1) % period(m_act)) == 0) ? 1 : 0;
    m_set = (m_run != 0 && m_w == W - 1) ? 1 : 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
`ifndef DISTINGUISH_PULSE_JITTER_EN
    chk("m_cmp", int'(cmp_out), m_cmp);
    chk("m_wp", int'(win_pulses), m_wp);
`endif
    chk("m_set", int'(set_out), m_set);
    chk("m_act", int'(cls_act), m_act);
    chk("m_err", int'(cls_err), m_err);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cmp"}, int'(cmp_out), 0);
    chk({tag, "_set"}, int'(set_out), 0);
    chk({tag, "_act"}, int'(cls_act), 0);
    chk({tag, "_wp"}, int'(win_pulses), 0);
    chk({tag, "_err"}, int'(cls_err), 0);
  endtask

  typedef struct {
    bit en; bit load; int cls; int n;
    int e_cmp; int e_set; int e_act; int e_wp; int e_err;
  } vec_t;
  vec_t tbl[14];

  initial begin
    int nc, ns, guard;
    tbl[0]  = '{1'b0, 1'b1, 0,  1,    0, 0, 0, 0,  0};
    tbl[1]  = '{1'b1, 1'b0, 0,  1000, 10, 1, 0, 0, 0};
    tbl[2]  = '{1'b1, 1'b0, 0,  450,  4, 0, 0, 10, 0};
    tbl[3]  = '{1'b1, 1'b1, 3,  550,  6, 1, 0, 10, 0};
    tbl[4]  = '{1'b1, 1'b0, 0,  1000, 2, 1, 3, 10, 0};
    tbl[5]  = '{1'b1, 1'b1, 5,  100,  0, 0, 3, 2,  0};
    tbl[6]  = '{1'b1, 1'b1, 9,  900,  2, 1, 3, 2,  0};
    tbl[7]  = '{1'b1, 1'b0, 0,  1000, 1, 1, 9, 2,  0};
    tbl[8]  = '{1'b1, 1'b1, 12, 1,    0, 0, 9, 1,  1};
    tbl[9]  = '{1'b1, 1'b0, 0,  1,    0, 0, 9, 1,  0};
    tbl[10] = '{1'b1, 1'b1, 0,  498,  0, 0, 9, 1,  0};
    tbl[11] = '{1'b0, 1'b0, 0,  1,    0, 0, 0, 1,  0};
    tbl[12] = '{1'b0, 1'b0, 0,  5,    0, 0, 0, 1,  0};
    tbl[13] = '{1'b1, 1'b0, 0,  100,  1, 0, 0, 1,  0};

    model_reset();
    #1;
    chk_zero("reset");
    #1 rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      nc = 0;
      ns = 0;
      en = tbl[i].en;
      cls_load = tbl[i].load;
      cls_in = 4'(tbl[i].cls);
      for (int k = 0; k < tbl[i].n; k++) begin
        step();
        cls_load = 1'b0;
        nc += int'(cmp_out);
        ns += int'(set_out);
      end
`ifndef DISTINGUISH_PULSE_JITTER_EN
      chk($sformatf("v%0d_cmp_count", i), nc, tbl[i].e_cmp);
      chk($sformatf("v%0d_wp", i), int'(win_pulses), tbl[i].e_wp);
`endif
      chk($sformatf("v%0d_set_count", i), ns, tbl[i].e_set);
      chk($sformatf("v%0d_act", i), int'(cls_act), tbl[i].e_act);
      chk($sformatf("v%0d_err", i), int'(cls_err), tbl[i].e_err);
    end

    for (int k = 0; k < 30000; k++) begin
      if (m_run != 0) en = ($urandom_range(0, 1999) != 0);
      else            en = ($urandom_range(0, 3) == 0);
      cls_load = ($urandom_range(0, 149) == 0);
      cls_in = 4'($urandom_range(0, 15));
      step();
    end

    // Asynchronous reset in the middle of a running window
    en = 1'b1;
    cls_load = 1'b1;
    cls_in = 4'd4;
    step();
    cls_load = 1'b0;
    guard = 0;
    while (!(m_run != 0 && m_w == 300) && guard < 3000) begin
      step();
      guard++;
    end
    chk("midrst_reach_300", (guard < 3000) ? 1 : 0, 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_zero("midrst");
    #2 rst_n = 1'b1;
    for (int k = 0; k < 1200; k++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
